// File: rtl/sad_accum_pkg.sv
// Shared definitions for the sum-of-absolute-differences stage.
package sad_accum_pkg;

    // Frame controller states: ACCUM collects samples, DONE presents the result.
    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } sad_state_e;

endpackage : sad_accum_pkg

// File: rtl/sad_accum_abs.sv
// Absolute value of a two's-complement value, returned as an unsigned
// magnitude of the same width. The most-negative input maps to 2^(W-1),
// which still fits in W unsigned bits, so no overflow case exists.
module sad_accum_abs #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] val_i,
    output logic [DATAWIDTH-1:0] mag_o
);

    // Negate when the sign bit is set; otherwise pass through.
    always_comb begin
        mag_o = val_i;
        if (val_i[DATAWIDTH-1]) begin
            mag_o = (~val_i) + DATAWIDTH'(1);
        end
    end

endmodule : sad_accum_abs

// File: rtl/sad_accum.sv
// Frame-level sum of absolute differences with saturation and a
// valid/ready result handshake. One result per COUNT accepted samples.
module sad_accum
    import sad_accum_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int COUNT     = 16,
    parameter int ACCWIDTH  = 12
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 clr,
    input  logic [DATAWIDTH-1:0] diff,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ACCWIDTH-1:0]  sum,
    output logic                 sat,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int                CNTW    = $clog2(COUNT + 1);
    localparam logic [CNTW-1:0]   LAST    = CNTW'(COUNT - 1);
    localparam logic [ACCWIDTH-1:0] ACC_MAX = '1;

    sad_state_e          state_q;
    logic [ACCWIDTH-1:0] acc_q;
    logic [CNTW-1:0]     cnt_q;
    logic [ACCWIDTH-1:0] sum_q;
    logic                sat_q;
    logic                sat_pend_q;

    logic [DATAWIDTH-1:0] mag;
    logic [ACCWIDTH:0]    acc_wide;
    logic [ACCWIDTH-1:0]  acc_d;
    logic                 ovf;
    logic                 accept;

    sad_accum_abs #(
        .DATAWIDTH(DATAWIDTH)
    ) u_abs (
        .val_i(diff),
        .mag_o(mag)
    );

    assign in_ready  = (state_q == ACCUM) && !Rst;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign sat       = sat_q;
    assign accept    = in_valid && in_ready;

    // One extra bit of headroom catches overflow; the result is then clamped.
    // Once acc sits at max every further add overflows, so it stays pinned.
    always_comb begin
        acc_wide = {1'b0, acc_q} + {{(ACCWIDTH + 1 - DATAWIDTH){1'b0}}, mag};
        ovf      = acc_wide[ACCWIDTH];
        acc_d    = ovf ? ACC_MAX : acc_wide[ACCWIDTH-1:0];
    end

    // Frame controller, sample counter, accumulator and result registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            sat_q      <= 1'b0;
            sat_pend_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (clr) begin
                        // Abort: drop the partial frame and this cycle's sample.
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        sat_pend_q <= 1'b0;
                    end else if (accept) begin
                        if (cnt_q == LAST) begin
                            sum_q      <= acc_d;
                            sat_q      <= sat_pend_q | ovf;
                            acc_q      <= '0;
                            cnt_q      <= '0;
                            sat_pend_q <= 1'b0;
                            state_q    <= DONE;
                        end else begin
                            acc_q      <= acc_d;
                            sat_pend_q <= sat_pend_q | ovf;
                            cnt_q      <= cnt_q + CNTW'(1);
                        end
                    end
                end
                DONE: begin
                    // clr is ignored here so a finished result is never lost.
                    if (out_ready) begin
                        state_q <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

endmodule : sad_accum

// File: tb/tb_sad_accum.sv
// Directed bench: three instances share stimulus and differ only in
// accumulator width (12, 9, 8 bits) so saturation shows up at different sums.
module tb_sad_accum;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       clr;
    logic [7:0] diff;
    logic       in_valid;
    logic       out_ready;

    logic        ir_a, ir_b, ir_c;
    logic        ov_a, ov_b, ov_c;
    logic [11:0] sum_a;
    logic [8:0]  sum_b;
    logic [7:0]  sum_c;
    logic        sat_a, sat_b, sat_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    sad_accum #(.DATAWIDTH(8), .COUNT(4), .ACCWIDTH(12)) dut_a (
        .Clk(Clk), .Rst(Rst), .clr(clr), .diff(diff), .in_valid(in_valid),
        .in_ready(ir_a), .sum(sum_a), .sat(sat_a), .out_valid(ov_a),
        .out_ready(out_ready)
    );

    sad_accum #(.DATAWIDTH(8), .COUNT(4), .ACCWIDTH(9)) dut_b (
        .Clk(Clk), .Rst(Rst), .clr(clr), .diff(diff), .in_valid(in_valid),
        .in_ready(ir_b), .sum(sum_b), .sat(sat_b), .out_valid(ov_b),
        .out_ready(out_ready)
    );

    sad_accum #(.DATAWIDTH(8), .COUNT(4), .ACCWIDTH(8)) dut_c (
        .Clk(Clk), .Rst(Rst), .clr(clr), .diff(diff), .in_valid(in_valid),
        .in_ready(ir_c), .sum(sum_c), .sat(sat_c), .out_valid(ov_c),
        .out_ready(out_ready)
    );

    typedef struct {
        logic [7:0] diff;
        logic       iv;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        int         e_sa;
        logic       e_ta;
        int         e_sb;
        logic       e_tb;
        int         e_sc;
        logic       e_tc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic iv, input logic ordy,
                         input logic c, input logic r);
        diff      = d;
        in_valid  = iv;
        out_ready = ordy;
        clr       = c;
        Rst       = r;
    endtask

    // Status of all three instances in one call: in_ready/out_valid must agree.
    task automatic chk_all(input string nm, input logic e_ir, input logic e_ov,
                           input int e_sa, input logic e_ta, input int e_sb,
                           input logic e_tb, input int e_sc, input logic e_tc);
        chk({nm, " in_ready_a"},  int'(ir_a), int'(e_ir));
        chk({nm, " in_ready_b"},  int'(ir_b), int'(e_ir));
        chk({nm, " in_ready_c"},  int'(ir_c), int'(e_ir));
        chk({nm, " out_valid_a"}, int'(ov_a), int'(e_ov));
        chk({nm, " out_valid_b"}, int'(ov_b), int'(e_ov));
        chk({nm, " out_valid_c"}, int'(ov_c), int'(e_ov));
        chk({nm, " sum_a"}, int'(sum_a), e_sa);
        chk({nm, " sat_a"}, int'(sat_a), int'(e_ta));
        chk({nm, " sum_b"}, int'(sum_b), e_sb);
        chk({nm, " sat_b"}, int'(sat_b), int'(e_tb));
        chk({nm, " sum_c"}, int'(sum_c), e_sc);
        chk({nm, " sat_c"}, int'(sat_c), int'(e_tc));
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic iv, input logic ordy,
                                input logic e_ir, input logic e_ov,
                                input int sa, input logic ta, input int sb, input logic tb,
                                input int sc, input logic tc);
        vec_t v;
        v.diff = d;  v.iv = iv;  v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov;
        v.e_sa = sa; v.e_ta = ta; v.e_sb = sb; v.e_tb = tb; v.e_sc = sc; v.e_tc = tc;
        return v;
    endfunction

    initial begin
        // Frame 1: |3|+|-3|+|10|+|-10| = 26 everywhere, then result taken.
        vecs.push_back(mk(8'h03, 1, 1, 1, 0,   0, 0,   0, 0,   0, 0));
        vecs.push_back(mk(8'hFD, 1, 1, 1, 0,   0, 0,   0, 0,   0, 0));
        vecs.push_back(mk(8'h0A, 1, 1, 1, 0,   0, 0,   0, 0,   0, 0));
        vecs.push_back(mk(8'hF6, 1, 1, 0, 1,  26, 0,  26, 0,  26, 0));
        vecs.push_back(mk(8'h00, 0, 1, 1, 0,  26, 0,  26, 0,  26, 0));
        // Frame 2: 4 x 0x80 = 512; 9-bit clamps to 511, 8-bit to 255.
        vecs.push_back(mk(8'h80, 1, 1, 1, 0,  26, 0,  26, 0,  26, 0));
        vecs.push_back(mk(8'h80, 1, 1, 1, 0,  26, 0,  26, 0,  26, 0));
        vecs.push_back(mk(8'h80, 1, 1, 1, 0,  26, 0,  26, 0,  26, 0));
        vecs.push_back(mk(8'h80, 1, 1, 0, 1, 512, 0, 511, 1, 255, 1));
        vecs.push_back(mk(8'h00, 0, 1, 1, 0, 512, 0, 511, 1, 255, 1));
        // Frame 3: 128+128+1+1 = 258; 8-bit saturates mid-frame and stays.
        vecs.push_back(mk(8'h80, 1, 1, 1, 0, 512, 0, 511, 1, 255, 1));
        vecs.push_back(mk(8'h80, 1, 1, 1, 0, 512, 0, 511, 1, 255, 1));
        vecs.push_back(mk(8'h01, 1, 1, 1, 0, 512, 0, 511, 1, 255, 1));
        vecs.push_back(mk(8'h01, 1, 1, 0, 1, 258, 0, 258, 0, 255, 1));
        vecs.push_back(mk(8'h00, 0, 1, 1, 0, 258, 0, 258, 0, 255, 1));
        // Frame 4: 4 x 1 = 4, saturation flag cleared per frame.
        vecs.push_back(mk(8'h01, 1, 1, 1, 0, 258, 0, 258, 0, 255, 1));
        vecs.push_back(mk(8'h01, 1, 1, 1, 0, 258, 0, 258, 0, 255, 1));
        vecs.push_back(mk(8'h01, 1, 1, 1, 0, 258, 0, 258, 0, 255, 1));
        vecs.push_back(mk(8'h01, 1, 1, 0, 1,   4, 0,   4, 0,   4, 0));
        vecs.push_back(mk(8'h00, 0, 1, 1, 0,   4, 0,   4, 0,   4, 0));

        // Reset state.
        drive(8'h00, 0, 1, 0, 1);
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(8'h00, 0, 1, 0, 0);
        #1;
        chk("reset_release in_ready", int'(ir_a), 1);

        // Table-driven frames.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].diff, vecs[i].iv, vecs[i].ordy, 0, 0);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov,
                    vecs[i].e_sa, vecs[i].e_ta, vecs[i].e_sb, vecs[i].e_tb,
                    vecs[i].e_sc, vecs[i].e_tc);
        end

        // Backpressure: frame 1..4 completes with out_ready low.
        for (int i = 1; i <= 4; i++) begin
            drive(8'(i), 1, 0, 0, 0);
            tick();
        end
        chk_all("bp_done", 0, 1, 10, 0, 10, 0, 10, 0);
        drive(8'h05, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all($sformatf("bp_hold%0d", i), 0, 1, 10, 0, 10, 0, 10, 0);
        end
        drive(8'h05, 1, 1, 0, 0);
        tick();
        chk_all("bp_release", 1, 0, 10, 0, 10, 0, 10, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(8'h01, 1, 1, 0, 0);
            tick();
        end
        chk_all("bp_next_frame", 0, 1, 8, 0, 8, 0, 8, 0);
        drive(8'h00, 0, 1, 0, 0);
        tick();

        // clr after two accepted samples drops the presented sample too.
        drive(8'h05, 1, 1, 0, 0);
        tick();
        tick();
        drive(8'h05, 1, 1, 1, 0);
        tick();
        chk_all("clr_cycle", 1, 0, 8, 0, 8, 0, 8, 0);
        for (int i = 0; i < 3; i++) begin
            drive(8'h01, 1, 1, 0, 0);
            tick();
        end
        chk_all("clr_not_early", 1, 0, 8, 0, 8, 0, 8, 0);
        tick();
        chk_all("clr_frame", 0, 1, 4, 0, 4, 0, 4, 0);
        drive(8'h00, 0, 1, 0, 0);
        tick();

        // clr ignored in DONE, then Rst discards the pending result.
        for (int i = 0; i < 4; i++) begin
            drive(8'h03, 1, 0, 0, 0);
            tick();
        end
        chk_all("rst_pre_done", 0, 1, 12, 0, 12, 0, 12, 0);
        drive(8'h00, 0, 0, 1, 0);
        tick();
        chk_all("clr_in_done", 0, 1, 12, 0, 12, 0, 12, 0);
        drive(8'h00, 0, 0, 0, 1);
        tick();
        chk_all("rst_in_done", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(8'h00, 0, 1, 0, 0);
        #1;
        chk("rst_release in_ready", int'(ir_b), 1);
        for (int i = 0; i < 4; i++) begin
            drive(8'h02, 1, 1, 0, 0);
            tick();
        end
        chk_all("rst_fresh_frame", 0, 1, 8, 0, 8, 0, 8, 0);
        drive(8'h00, 0, 1, 0, 0);
        tick();
        chk_all("rst_fresh_taken", 1, 0, 8, 0, 8, 0, 8, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sad_accum

// File: doc/sad_accum.md
# sad_accum

Sequential stage directly downstream of the subtractor: consumes a stream of DATAWIDTH-bit two's-complement differences and accumulates their absolute values over a frame of COUNT samples. Emits one saturating sum-of-absolute-differences per frame with a valid/ready handshake. Provides the frame-level reduction the datapath needs after the per-sample SUB stage.

## Interface
- DATAWIDTH, 8, width of incoming difference (matches SUB output)
- COUNT, 16, samples per frame; legal range 1..2^16-1
- ACCWIDTH, 12, width of accumulated sum; must be >= DATAWIDTH
- Clk  input  1  single clock, all state updates on rising edge
- Rst  input  1  reset, synchronous and active-high
- clr  input  1  synchronous frame abort: discard partial frame
- diff  input  DATAWIDTH  difference sample, two's complement
- in_valid  input  1  diff is valid this cycle
- in_ready  output  1  block accepts diff this cycle
- sum  output  ACCWIDTH  frame result, unsigned, saturated
- sat  output  1  saturation occurred in the frame reported on sum
- out_valid  output  1  sum/sat valid
- out_ready  input  1  downstream takes result this cycle

## Operation
- States: ACCUM, DONE. Reset state ACCUM.
- Reset values: acc=0, cnt=0, sum=0, sat=0, out_valid=0, sat_pending=0; in_ready=0 while Rst high, 1 in ACCUM otherwise.
- in_ready = (state==ACCUM) && !Rst. out_valid = (state==DONE).
- Accept = in_valid && in_ready. On accept: mag = |diff|; acc <= min(acc + mag, 2^ACCWIDTH-1); sat_pending set if the unclamped sum exceeded the max; cnt <= cnt+1.
- Absolute value: MSB clear -> diff; MSB set -> (~diff)+1 taken as DATAWIDTH-bit unsigned; most-negative input (0x80 at 8 bits) gives 128, no overflow.
- Addition done at ACCWIDTH+1 bits, then clamped; once saturated, acc stays at max for the rest of the frame.
- On accept with cnt==COUNT-1: sum <= clamped result, sat <= sat_pending or this sample's overflow, acc<=0, cnt<=0, sat_pending<=0, state -> DONE.
- DONE: in_ready=0, sum/sat held stable. out_valid && out_ready -> state ACCUM next edge; no same-cycle sample acceptance (no bypass).
- clr in ACCUM: acc, cnt, sat_pending <= 0; sample presented in that cycle is dropped even if in_valid; sum/sat unchanged.
- clr in DONE: ignored; result is still delivered.
- Rst has priority over clr; clr has priority over accept.
- in_valid low: no state change. Downstream may hold out_ready high permanently.

## Timing
- Sample-to-result latency: out_valid rises on the edge that accepts the COUNT-th sample (registered, visible next cycle).
- Throughput: COUNT accepted samples + minimum 1 DONE cycle per frame.
- in_valid/diff must be held until accepted; out_valid/sum held until taken.
- Rst mid-frame or in DONE: all state returns to reset values on that edge; a pending result is lost.
- COUNT=1: every accepted sample produces a result; alternates ACCUM/DONE.

## Structure
- Shared constants file: state encodings (ACCUM=1'b0, DONE=1'b1); no other shared definitions.
- cnt width = clog2(COUNT+1) computed locally.
- One sub-module: ABS (combinational, parameter DATAWIDTH, in -> unsigned magnitude), reusable elsewhere in the datapath.
- Top holds FSM, counter, saturating accumulator, output registers.

## Test plan
- COUNT=4, ACCWIDTH=12: diffs 0x03, 0xFD, 0x0A, 0xF6 back-to-back, out_ready=1 -> sum=26, sat=0, out_valid one cycle, in_ready back to 1 next cycle.
- COUNT=4: four samples of 0x80 -> sum=512, sat=0 (most-negative magnitude is 128).
- COUNT=4, ACCWIDTH=9: four 0x80 -> sum=511, sat=1; next frame of 0x01 x4 -> sum=4, sat=0 (sat cleared per frame).
- Backpressure: frame of 1,2,3,4 completes, out_ready low 5 cycles with in_valid high -> in_ready=0, sum=10 stable, no samples consumed; out_ready high -> next frame starts following cycle with the held sample.
- clr after 2 accepted samples (5,5) with in_valid high on the clr cycle -> that sample dropped; next 4 samples of 1 -> sum=4.
- Rst asserted in DONE with out_ready low -> next cycle out_valid=0, sum=0, sat=0, in_ready=1 after Rst release; fresh frame of 2 x4 -> sum=8.
